// File: rtl/wb_pkg.sv
// Shared types and sizing for the register-file writeback path.
package wb_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small registered FIFO buffering long-latency writeback results.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push_valid,
  output logic      o_push_ready,
  input  wb_entry_t i_push_entry,
  input  logic      i_pop,
  output logic      o_empty,
  output wb_entry_t o_head
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  wb_entry_t     r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  // Ready depends only on the current count, so a same-cycle pop never frees a slot early.
  assign o_push_ready = (r_count != CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_head       = r_mem[r_rd_ptr];
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter_64bit.sv
// Register-file write port arbiter: ALU results win over buffered long-latency
// results; a busy scoreboard tracks pending long-latency destinations.
module writeback_arbiter_64bit
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            long_valid,
  output logic            long_ready,
  input  logic [4:0]      long_rd,
  input  logic [XLEN-1:0] long_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_data;
  logic                r_wen;
  logic                w_alu_win;
  logic                w_fifo_empty;
  logic                w_pop;
  wb_entry_t           w_head;
  wb_entry_t           w_push_entry;

  assign w_alu_win    = alu_valid && (alu_rd != '0);
  assign w_pop        = !w_alu_win && !w_fifo_empty;
  assign w_push_entry = '{rd: long_rd, data: long_data};

  // x0 long results are handshaken through long_ready but never enqueued.
  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push_valid (long_valid && (long_rd != '0)),
    .o_push_ready (long_ready),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_empty      (w_fifo_empty),
    .o_head       (w_head)
  );

  // Set after clear so a same-cycle reissue of the popping rd stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head.rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_rd   <= '0;
      r_data <= '0;
      r_wen  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_alu_win) begin
        r_rd   <= alu_rd;
        r_data <= alu_data;
        r_wen  <= 1'b1;
      end else if (w_pop) begin
        r_rd   <= w_head.rd;
        r_data <= w_head.data;
        r_wen  <= 1'b1;
      end else begin
        r_wen  <= 1'b0;
      end
    end
  end

  assign rs1_busy   = r_busy[rs1];
  assign rs2_busy   = r_busy[rs2];
  assign rd         = r_rd;
  assign write_data = r_data;
  assign reg_write  = r_wen;
endmodule

// File: tb/tb_writeback_arbiter_64bit.sv
// Directed bench for writeback_arbiter_64bit with a queue-based reference model.
module tb_writeback_arbiter_64bit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, long_valid, issue_valid;
  logic [4:0]  alu_rd, long_rd, issue_rd, rs1, rs2;
  logic [63:0] alu_data, long_data;
  logic        long_ready, rs1_busy, rs2_busy, reg_write;
  logic [4:0]  rd;
  logic [63:0] write_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          cmp_en   = 1'b0;

  always #5 clk = ~clk;

  writeback_arbiter_64bit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .long_valid  (long_valid),
    .long_ready  (long_ready),
    .long_rd     (long_rd),
    .long_data   (long_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd          (rd),
    .write_data  (write_data),
    .reg_write   (reg_write)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending results as a queue, busy as a bit array.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;
  ent_t        mq[$];
  ent_t        m_e;
  bit          mbusy[32];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          m_acc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_rw = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      m_acc = long_valid && (mq.size() < FIFO_DEPTH);
      if (alu_valid && alu_rd != 0) begin
        m_rw = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
        m_e = mq.pop_front();
        m_rw = 1'b1; m_rd = m_e.rd; m_data = m_e.data;
        mbusy[m_e.rd] = 1'b0;
      end else begin
        m_rw = 1'b0;
      end
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
      if (m_acc && long_rd != 0) mq.push_back('{long_rd, long_data});
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      chk("model reg_write", reg_write, m_rw);
      if (m_rw) begin
        chk("model rd", rd, m_rd);
        chk("model write_data", write_data, m_data);
      end
      chk("model long_ready", long_ready, mq.size() < FIFO_DEPTH);
      chk("model rs1_busy", rs1_busy, mbusy[rs1]);
      chk("model rs2_busy", rs2_busy, mbusy[rs2]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    long_valid = 1'b0; long_rd = '0; long_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    rs1 = '0; rs2 = '0;
    #12;
    chk("reset reg_write", reg_write, 1'b0);
    chk("reset rd", rd, 5'd0);
    cyc();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);
    chk("post-reset long_ready", long_ready, 1'b1);

    // ALU result appears one cycle later
    cyc(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hDEAD_BEEF;
    cyc(); idle();
    @(negedge clk);
    chk("alu reg_write", reg_write, 1'b1);
    chk("alu rd", rd, 5'd3);
    chk("alu data", write_data, 64'hDEAD_BEEF);

    // Issue rd7, long result two cycles to writeback, busy clears with it
    cyc(); issue_valid = 1'b1; issue_rd = 5'd7;
    cyc(); idle(); rs1 = 5'd7;
    long_valid = 1'b1; long_rd = 5'd7; long_data = 64'h1234;
    @(negedge clk);
    chk("rd7 busy after issue", rs1_busy, 1'b1);
    chk("long_ready empty", long_ready, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("long N+1 no write", reg_write, 1'b0);
    chk("rd7 still busy", rs1_busy, 1'b1);
    cyc();
    @(negedge clk);
    chk("long N+2 write", reg_write, 1'b1);
    chk("long N+2 rd", rd, 5'd7);
    chk("long N+2 data", write_data, 64'h1234);
    chk("rd7 cleared", rs1_busy, 1'b0);

    // ALU holds the port four cycles; FIFO fills then drains in order
    for (int i = 0; i < 4; i++) begin
      cyc();
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 64'(100 + i);
      long_valid = 1'b1;
      long_rd = (i < 2) ? 5'(10 + i) : 5'd12;
      long_data = (i < 2) ? 64'(160 + i) : 64'hC2;
      @(negedge clk);
      chk("fill long_ready", long_ready, (i < 2) ? 1'b1 : 1'b0);
    end
    cyc(); idle();
    @(negedge clk);
    chk("last alu rd", rd, 5'd4);
    cyc();
    @(negedge clk);
    chk("drain0 rd", rd, 5'd10);
    chk("drain0 data", write_data, 64'd160);
    cyc();
    @(negedge clk);
    chk("drain1 rd", rd, 5'd11);
    chk("drain1 data", write_data, 64'd161);
    cyc();
    @(negedge clk);
    chk("drained idle", reg_write, 1'b0);

    // alu_rd=0 lets FIFO drain; long rd=0 is discarded
    cyc(); alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h55;
    long_valid = 1'b1; long_rd = 5'd9; long_data = 64'h99;
    cyc(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBAD;
    long_valid = 1'b1; long_rd = 5'd0; long_data = 64'hBAD0;
    @(negedge clk);
    chk("x0 prev alu rd", rd, 5'd2);
    cyc(); idle();
    @(negedge clk);
    chk("x0 drain write", reg_write, 1'b1);
    chk("x0 drain rd", rd, 5'd9);
    chk("x0 drain data", write_data, 64'h99);
    cyc();
    @(negedge clk);
    chk("x0 long never writes", reg_write, 1'b0);

    // Reissue of rd4 on the pop cycle keeps it busy
    cyc(); issue_valid = 1'b1; issue_rd = 5'd4;
    cyc(); idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    long_valid = 1'b1; long_rd = 5'd4; long_data = 64'h44;
    cyc(); idle(); issue_valid = 1'b1; issue_rd = 5'd4;
    cyc(); idle(); rs2 = 5'd4;
    @(negedge clk);
    chk("reissue pop rd", rd, 5'd4);
    chk("reissue busy4", rs2_busy, 1'b1);

    // Reset with FIFO full and busy[5] set
    cyc(); issue_valid = 1'b1; issue_rd = 5'd5;
    cyc(); idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    long_valid = 1'b1; long_rd = 5'd20; long_data = 64'h20;
    cyc(); alu_rd = 5'd2; long_rd = 5'd21; long_data = 64'h21;
    cyc(); alu_rd = 5'd3; long_rd = 5'd22; long_data = 64'h22; rs1 = 5'd5;
    @(negedge clk);
    chk("pre-reset full", long_ready, 1'b0);
    chk("pre-reset busy5", rs1_busy, 1'b1);
    #2;
    cmp_en  = 1'b0;
    reset_n = 1'b0;
    idle();
    #1;
    chk("mid reset reg_write", reg_write, 1'b0);
    cyc();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);
    chk("after reset long_ready", long_ready, 1'b1);
    chk("after reset busy5", rs1_busy, 1'b0);
    chk("after reset busy4", rs2_busy, 1'b0);
    chk("after reset reg_write", reg_write, 1'b0);
    cyc();
    @(negedge clk);
    chk("reset dropped fifo", reg_write, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
